// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths, skid-buffer
// state encoding and a payload-width helper.
package ex_mem_pipe_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RD_W_DEF  = 5;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_HALF  = ST_HALF,
        S_FULL  = ST_FULL
    } skid_state_e;

    // Bits in one EX/MEM payload: address, store data, branch op, 7 flag/control bits, rd.
    function automatic int payload_bits(input int width, input int rd_w);
        return 2 * width + 2 + 7 + rd_w;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_reg.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a flop, so out_ready never
// reaches in_ready combinationally. clr drops every held entry and any same-cycle input.
module skid_reg
    import ex_mem_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         ready_q;
    logic         in_fire, out_fire;
    logic         load_main, load_skid, main_from_skid;

    assign in_fire   = in_valid & ready_q;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d   = S_HALF;
                    load_main = 1'b1;
                end
            end
            S_HALF: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_d   = S_FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    state_d        = S_HALF;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // A completing head still leaves through out_fire; everything behind it dies.
        if (clr) begin
            state_d   = S_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_FULL);
            if (load_main) main_q <= main_from_skid ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: packs the EX payload into a skid buffer, squashes
// wrong-path entries on a MEM-resolved taken branch and gates MEM control bits with o_valid.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RD_W  = RD_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [1:0]       i_branch_op,
    input  logic             i_negative,
    input  logic             i_zero,
    input  logic             i_branch,
    input  logic             i_mem_write,
    input  logic             i_mem_read,
    input  logic             i_slt,
    input  logic             i_reg_write,
    input  logic [RD_W-1:0]  i_rd,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_address,
    output logic [WIDTH-1:0] o_write_data,
    output logic [1:0]       o_branch_op,
    output logic             o_negative,
    output logic             o_zero,
    output logic             o_branch,
    output logic             o_mem_write,
    output logic             o_mem_read,
    output logic             o_slt,
    output logic             o_reg_write,
    output logic [RD_W-1:0]  o_rd,
    output logic [1:0]       o_occupancy
);

    typedef struct packed {
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] write_data;
        logic [1:0]       branch_op;
        logic             negative;
        logic             zero;
        logic             branch;
        logic             mem_write;
        logic             mem_read;
        logic             slt;
        logic             reg_write;
        logic [RD_W-1:0]  rd;
    } ex_mem_payload_t;

    localparam int PW = payload_bits(WIDTH, RD_W);

    ex_mem_payload_t in_pl, out_pl;
    logic [PW-1:0]   out_bits;

    assign in_pl = '{
        alu_result: i_alu_result,
        write_data: i_write_data,
        branch_op:  i_branch_op,
        negative:   i_negative,
        zero:       i_zero,
        branch:     i_branch,
        mem_write:  i_mem_write,
        mem_read:   i_mem_read,
        slt:        i_slt,
        reg_write:  i_reg_write,
        rd:         i_rd
    };

    skid_reg #(.W(PW)) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (i_flush),
        .in_valid  (i_valid),
        .in_ready  (o_ready),
        .in_data   (in_pl),
        .out_valid (o_valid),
        .out_ready (i_ready),
        .out_data  (out_bits),
        .occupancy (o_occupancy)
    );

    assign out_pl = out_bits;

    assign o_address    = out_pl.alu_result;
    assign o_write_data = out_pl.write_data;
    assign o_branch_op  = out_pl.branch_op;
    assign o_negative   = out_pl.negative;
    assign o_zero       = out_pl.zero;
    assign o_slt        = out_pl.slt;
    assign o_rd         = out_pl.rd;

    // Side-effecting controls must never leak from a stale, invalid slot.
    assign o_branch    = o_valid & out_pl.branch;
    assign o_mem_write = o_valid & out_pl.mem_write;
    assign o_mem_read  = o_valid & out_pl.mem_read;
    assign o_reg_write = o_valid & out_pl.reg_write;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: a FIFO model of at most two in-flight items,
// fed by directed scenarios and then randomized valid/ready/flush/reset traffic.
module tb_ex_mem_pipe;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  bop;
        logic        neg, zero, br, mw, mr, slt, rw;
        logic [4:0]  rd;
    } item_t;

    logic        clk = 1'b0;
    logic        i_rst, i_flush, i_valid, i_ready;
    logic [31:0] i_alu_result, i_write_data;
    logic [1:0]  i_branch_op;
    logic        i_negative, i_zero, i_branch, i_mem_write, i_mem_read, i_slt, i_reg_write;
    logic [4:0]  i_rd;
    logic        o_ready, o_valid;
    logic [31:0] o_address, o_write_data;
    logic [1:0]  o_branch_op;
    logic        o_negative, o_zero, o_branch, o_mem_write, o_mem_read, o_slt, o_reg_write;
    logic [4:0]  o_rd;
    logic [1:0]  o_occupancy;

    item_t exp_q[$];
    item_t head;
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;
    logic  ready_m;

    ex_mem_pipe #(.WIDTH(32), .RD_W(5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_branch_op(i_branch_op),
        .i_negative(i_negative), .i_zero(i_zero), .i_branch(i_branch), .i_mem_write(i_mem_write),
        .i_mem_read(i_mem_read), .i_slt(i_slt), .i_reg_write(i_reg_write), .i_rd(i_rd),
        .o_valid(o_valid), .i_ready(i_ready), .o_address(o_address), .o_write_data(o_write_data),
        .o_branch_op(o_branch_op), .o_negative(o_negative), .o_zero(o_zero), .o_branch(o_branch),
        .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .o_slt(o_slt),
        .o_reg_write(o_reg_write), .o_rd(o_rd), .o_occupancy(o_occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [31:0] a, input logic br, input logic mw);
        item_t it;
        it.addr  = a;
        it.wdata = $urandom;
        it.bop   = 2'($urandom_range(0, 3));
        it.neg   = 1'($urandom_range(0, 1));
        it.zero  = 1'($urandom_range(0, 1));
        it.br    = br;
        it.mw    = mw;
        it.mr    = 1'($urandom_range(0, 1));
        it.slt   = 1'($urandom_range(0, 1));
        it.rw    = 1'($urandom_range(0, 1));
        it.rd    = 5'($urandom_range(0, 31));
        return it;
    endfunction

    // One clock: drive inputs, let the edge happen, then advance the reference FIFO.
    task automatic step(input logic v, input item_t it, input logic rdy, input logic fl, input logic rs);
        i_valid      = v;
        i_alu_result = it.addr;
        i_write_data = it.wdata;
        i_branch_op  = it.bop;
        i_negative   = it.neg;
        i_zero       = it.zero;
        i_branch     = it.br;
        i_mem_write  = it.mw;
        i_mem_read   = it.mr;
        i_slt        = it.slt;
        i_reg_write  = it.rw;
        i_rd         = it.rd;
        i_ready      = rdy;
        i_flush      = fl;
        i_rst        = rs;
        ready_m      = (exp_q.size() < 2);
        @(posedge clk);
        #1;
        if (rs || fl) exp_q.delete();
        else if (v && ready_m) exp_q.push_back(it);
    endtask

    // Monitor: mid-cycle, compare the presented head and pop it on a completing handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_valid", 64'(o_valid), 64'(exp_q.size() != 0));
            chk("o_ready", 64'(o_ready), 64'(exp_q.size() < 2));
            chk("o_occupancy", 64'(o_occupancy), 64'(exp_q.size()));
            if (!o_valid)
                chk("gated_ctrl", 64'({o_branch, o_mem_write, o_mem_read, o_reg_write}), 64'(0));
            if (o_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                chk("o_address", 64'(o_address), 64'(head.addr));
                chk("payload",
                    64'({o_write_data, o_branch_op, o_negative, o_zero, o_branch, o_mem_write,
                         o_mem_read, o_slt, o_reg_write, o_rd}),
                    64'({head.wdata, head.bop, head.neg, head.zero, head.br, head.mw,
                         head.mr, head.slt, head.rw, head.rd}));
                if (i_ready && !i_rst) head = exp_q.pop_front();
            end
        end
    end

    initial begin
        item_t idle;
        idle = mk(32'h0, 1'b0, 1'b0);
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_alu_result = '0; i_write_data = '0; i_branch_op = '0; i_negative = 1'b0;
        i_zero = 1'b0; i_branch = 1'b0; i_mem_write = 1'b0; i_mem_read = 1'b0;
        i_slt = 1'b0; i_reg_write = 1'b0; i_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b0, idle, 1'b1, 1'b0, 1'b1);
        chk("reset_occ", 64'(o_occupancy), 64'(0));
        chk("reset_addr", 64'(o_address), 64'(0));

        // Streaming at full rate.
        step(1'b1, mk(32'h10, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("stream_lat", 64'(o_address), 64'(32'h10));
        step(1'b1, mk(32'h14, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
        step(1'b1, mk(32'h18, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
        chk("stream_occ", 64'(o_occupancy), 64'(1));
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Back-pressure fills both entries, then drains in order.
        step(1'b1, mk(32'hA0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'hA4, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
        chk("bp_ready", 64'(o_ready), 64'(0));
        chk("bp_occ", 64'(o_occupancy), 64'(2));
        step(1'b1, mk(32'hA8, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        chk("bp_second", 64'(o_address), 64'(32'hA4));
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);

        // Store visible for exactly one cycle, then gated off.
        step(1'b1, mk(32'h40, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        chk("store_on", 64'(o_mem_write), 64'(1));
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        chk("store_off", 64'(o_mem_write), 64'(0));

        // Flush with a full buffer: branch head completes, the rest vanish.
        step(1'b1, mk(32'h20, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h24, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h28, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0);
        chk("flush_valid", 64'(o_valid), 64'(0));
        chk("flush_ready", 64'(o_ready), 64'(1));
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b1, 1'b0);

        // Reset mid-stream with two entries held.
        step(1'b1, mk(32'h50, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(32'h54, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_occ", 64'(o_occupancy), 64'(0));
        chk("rst_ctrl", 64'({o_branch, o_mem_write, o_mem_read, o_reg_write}), 64'(0));

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            step(1'($urandom_range(0, 3) != 0), mk($urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1))), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 499) == 0));
        end
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0, 1'b0);
        chk("drained", 64'(o_occupancy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
